pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake
//   and ALU-style flags. It is the multi-cycle successor of the combinational 32-bit adder.
//   Operands are split into STAGES equal slices, and the carry ripples one slice per cycle.
//   Used by the datapath for wide address/ALU arithmetic where one-cycle carry is too slow.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 required (elab-time $error otherwise)
//   STAGES  2   pipeline depth and number of slices, 1..8; slice width SW = WIDTH/STAGES
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous reset, active-high
//   flush         in   1      synchronous kill of every in-flight operation
//   in_valid      in   1      operand beat valid
//   in_ready      out  1      block can accept a beat this cycle
//   in_a          in   WIDTH  operand A
//   in_b          in   WIDTH  operand B
//   in_sub        in   1      0: A+B, 1: A-B (A + ~B + 1)
//   out_valid     out  1      result valid
//   out_ready     in   1      consumer accepts result this cycle
//   out_result    out  WIDTH  sum/difference, modulo 2^WIDTH
//   out_carry     out  1      carry out of MSB (sub: 1 = no borrow)
//   out_overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB
//   out_zero      out  1      out_result == 0
// BEHAVIOUR
//   - Reset (async, rst=1): all stage valid bits 0, all data/carry/flag registers 0.
//     Hence out_valid=0, out_result=0, out_carry=0, out_overflow=0, out_zero=0.
//     in_ready=1 in the same cycle rst is high.
//   - Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational, no dependence on in_valid).
//     On adv, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}.
//     When !adv, all stages hold; no beat is lost or duplicated.
//   - Transfer rules: an input transfer occurs when in_valid & in_ready.
//     An output transfer occurs when out_valid & out_ready.
//     Bubbles are not collapsed; valid bits travel with data.
//   - Stage k (0..STAGES-1):
//     - Adds slice k of A and (in_sub ? ~B : B) plus the carry from stage k-1. Stage 0 carry-in = in_sub.
//     - Registers SW result bits and a carry bit.
//     - Upper slices of operands are skewed forward, unmodified.
//     - Already-computed lower result slices are carried forward (deskew).
//   - Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls.
//     Throughput is 1 op/cycle while out_ready=1.
//   - Flags are computed in the final stage from its slice and registered with out_result.
//     - out_overflow uses the carry into bit WIDTH-1 (inside the last slice).
//     - out_zero is valid only alongside out_valid; it is 0 whenever out_valid=0.
//   - in_sub is captured per beat and travels with that beat. Mixed add/sub streams are legal.
//   - flush=1:
//     - Clears all stage valid bits at the next edge; data may remain but is don't-care.
//     - Overrides adv; no new beat is accepted on a flush cycle even if in_valid & in_ready.
//     - in_ready stays per the adv rule.
//   - Simultaneous in and out transfer on a full pipe is allowed (adv=1). Occupancy is unchanged.
//   - rst asserted mid-operation discards every in-flight beat. Outputs go to reset values asynchronously.
//   - STAGES=1 degenerates to a single registered add, latency 1.
//   - Carry and overflow are well-defined for all inputs; no X propagation from held data.
// TESTING
//   1. WIDTH=32, STAGES=2, add:
//      A=0x0000FFFF, B=0x00000001 -> after 2 cycles result=0x00010000, carry=0, ovf=0, zero=0.
//      This covers cross-slice carry.
//   2. Sub, A=5, B=5 -> result=0, carry=1, ovf=0, zero=1.
//      Sub, A=0, B=1 -> result=0xFFFFFFFF, carry=0.
//   3. Overflow:
//      add 0x7FFFFFFF+1 -> 0x80000000, ovf=1, carry=0.
//      add 0xFFFFFFFF+1 -> 0, carry=1, zero=1, ovf=0.
//   4. Back-pressure: stream 6 beats, out_ready low for 3 cycles mid-stream -> in_ready=0 while stalled.
//      All 6 results emerge in order, each exactly once, with correct values.
//   5. Flush with 2 beats in flight -> next cycle out_valid=0, and neither beat ever appears.
//      A beat sent the following cycle appears after STAGES cycles.
//   6. Async rst mid-stream (STAGES=4, WIDTH=64) -> out_valid=0 immediately, outputs 0.
//      After release, random 1000-op add/sub stream matches reference model.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor. The operands are cut into
// STAGES slices; each stage adds one slice and hands its carry to the next
// stage one cycle later. Upper operand slices skew forward, finished lower
// result slices deskew forward, and the final stage registers the flags.

// One slice of the ripple: SW-bit add of a and (sub ? ~b : b) plus carry-in.
module pas_slice #(
   parameter int SW = 16
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          sub,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);
   logic [SW-1:0] bx;
   logic [SW:0]   t;

   assign bx          = sub ? ~b : b;
   assign t           = {1'b0, a} + {1'b0, bx} + {{SW{1'b0}}, cin};
   assign {cout, sum} = t;
endmodule

module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero
);
   localparam int SW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("pipelined_add_sub: STAGES must be 1..8");
   end
   if ((WIDTH % STAGES) != 0) begin : g_bad_width
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
   end

   // Stage registers: one entry per stage, data travels with its valid bit.
   logic [STAGES-1:0]            vld_pipe, sub_q, c_q;
   logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q;
   logic                         ovf_q, zero_q;

   // Stage inputs (predecessor's registers, or the ports for stage 0).
   logic [STAGES-1:0]            v_d, s_d, c_d, co;
   logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, r_d, r_nx;
   logic                         bx_msb, cin_msb, ovf_nx;
   logic                         adv;

   // Last-stage operand copies exist only for uniform indexing; never read.
   logic unused_bits;
   assign unused_bits = ^{a_q[L], b_q[L], sub_q[L]};

   // Whole pipe moves together whenever the output slot is free or being taken.
   assign adv      = !vld_pipe[L] | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0] sum;

      if (k == 0) begin : g_head
         assign v_d[k] = in_valid;
         assign s_d[k] = in_sub;
         assign c_d[k] = in_sub;          // +1 of the two's-complement negate
         assign a_d[k] = in_a;
         assign b_d[k] = in_b;
         assign r_d[k] = '0;
      end else begin : g_body
         assign v_d[k] = vld_pipe[k-1];
         assign s_d[k] = sub_q[k-1];
         assign c_d[k] = c_q[k-1];
         assign a_d[k] = a_q[k-1];
         assign b_d[k] = b_q[k-1];
         assign r_d[k] = r_q[k-1];
      end

      pas_slice #(.SW(SW)) u_slice (
         .a    (a_d[k][k*SW +: SW]),
         .b    (b_d[k][k*SW +: SW]),
         .sub  (s_d[k]),
         .cin  (c_d[k]),
         .sum  (sum),
         .cout (co[k])
      );

      // Slices at and above k are always zero in r_d, so OR-ing in is a merge.
      assign r_nx[k] = r_d[k] | (WIDTH'(sum) << (k*SW));
   end

   // Carry into the MSB is recovered from the MSB sum bit of the last slice.
   assign bx_msb  = s_d[L] ^ b_d[L][WIDTH-1];
   assign cin_msb = a_d[L][WIDTH-1] ^ bx_msb ^ r_nx[L][WIDTH-1];
   assign ovf_nx  = cin_msb ^ co[L];

   // Pipeline advance; flush only kills valid bits and blocks the new beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         sub_q    <= '0;
         c_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else if (adv) begin
         vld_pipe <= v_d;
         sub_q    <= s_d;
         c_q      <= co;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_nx;
         ovf_q    <= ovf_nx;
         zero_q   <= (r_nx[L] == '0);
      end
   end

   assign out_valid    = vld_pipe[L];
   assign out_result   = r_q[L];
   assign out_carry    = c_q[L];
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q & vld_pipe[L];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: a 32-bit/2-stage instance for the
// arithmetic, stall and flush scenarios, and a 64-bit/4-stage instance for
// async reset mid-stream followed by a long random add/sub stream.
module tb_pipelined_add_sub;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit, 2-stage instance
   logic        rst, flush, in_valid, in_sub, out_ready;
   logic [31:0] in_a, in_b;
   logic        in_ready, out_valid, out_carry, out_overflow, out_zero;
   logic [31:0] out_result;

   // 64-bit, 4-stage instance
   logic        rst_w, flush_w, in_valid_w, in_sub_w, out_ready_w;
   logic [63:0] in_a_w, in_b_w;
   logic        in_ready_w, out_valid_w, out_carry_w, out_overflow_w, out_zero_w;
   logic [63:0] out_result_w;

   int vectors     = 0;
   int miscompares = 0;

   pipelined_add_sub #(.WIDTH(32), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero)
   );

   pipelined_add_sub #(.WIDTH(64), .STAGES(4)) dut_w (
      .clk(clk), .rst(rst_w), .flush(flush_w),
      .in_valid(in_valid_w), .in_ready(in_ready_w), .in_a(in_a_w), .in_b(in_b_w), .in_sub(in_sub_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .out_result(out_result_w),
      .out_carry(out_carry_w), .out_overflow(out_overflow_w), .out_zero(out_zero_w)
   );

   task automatic test_reset();
      logic [36:0] got;
      rst = 1'b1; rst_w = 1'b1; flush = 1'b0; flush_w = 1'b0;
      in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      in_valid_w = 1'b0; in_sub_w = 1'b0; in_a_w = '0; in_b_w = '0; out_ready_w = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got = {in_ready, out_valid, out_result, out_carry, out_overflow, out_zero};
      vectors++;
      if (got !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset32: got %h want %h", got, {1'b1, 1'b0, 32'h0, 3'b000});
      end
      vectors++;
      if ({in_ready_w, out_valid_w, out_result_w, out_carry_w, out_overflow_w, out_zero_w} !==
          {1'b1, 1'b0, 64'h0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset64: ready=%b valid=%b res=%h c=%b o=%b z=%b want 1 0 0 0 0 0",
                  in_ready_w, out_valid_w, out_result_w, out_carry_w, out_overflow_w, out_zero_w);
      end
      @(posedge clk); #1;
      rst = 1'b0; rst_w = 1'b0;
      @(posedge clk); #1;
   endtask

   // One isolated op: checks exact 2-cycle latency, the result/flags, and drain.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] er, input logic ec,
                         input logic eo, input logic ez);
      logic [35:0] got, exp;
      out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_early: out_valid=%b want 0", nm, out_valid);
      end
      @(posedge clk); #1;
      got = {out_valid, out_result, out_carry, out_overflow, out_zero};
      exp = {1'b1, er, ec, eo, ez};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got v=%b r=%h c=%b o=%b z=%b want v=1 r=%h c=%b o=%b z=%b",
                  nm, got[35], got[34:3], got[2], got[1], got[0], er, ec, eo, ez);
      end
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, out_zero} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s_drain: out_valid=%b out_zero=%b want 0 0", nm, out_valid, out_zero);
      end
   endtask

   task automatic test_arith();
      run_op("add_xslice",  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
      run_op("sub_equal",   32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("sub_borrow",  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      run_op("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_op("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("sub_ovf",     32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
   endtask

   // Six back-to-back beats with out_ready low for cycles 3..5.
   task automatic test_backpressure();
      logic [31:0] ta[6], tb_[6], te[6];
      logic        ts[6];
      int          sent = 0;
      int          got  = 0;
      ta  = '{32'd1, 32'd10, 32'h100, 32'hFFFF,  32'd0,        32'h12345678};
      tb_ = '{32'd2, 32'd3,  32'h200, 32'h1,     32'd1,        32'h11111111};
      ts  = '{1'b0,  1'b1,   1'b0,    1'b0,      1'b1,         1'b0};
      te  = '{32'd3, 32'd7,  32'h300, 32'h10000, 32'hFFFFFFFF, 32'h23456789};
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 5);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            in_a = ta[sent]; in_b = tb_[sent]; in_sub = ts[sent];
         end
         #1;
         if (!out_ready) begin
            vectors++;
            if ({out_valid, in_ready} !== 2'b10) begin
               miscompares++;
               $display("FAIL bp_stall cyc%0d: out_valid=%b in_ready=%b want 1 0", cyc, out_valid, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (got >= 6) begin
               miscompares++;
               $display("FAIL bp_extra: unexpected result %h", out_result);
            end else if (out_result !== te[got]) begin
               miscompares++;
               $display("FAIL bp_result%0d: got %h want %h", got, out_result, te[got]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      vectors++;
      if (got != 6) begin
         miscompares++;
         $display("FAIL bp_count: got %0d results want 6", got);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b1; flush = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1;
      @(posedge clk); #1;
      in_a = 32'd2; in_b = 32'd2;
      @(posedge clk); #1;
      // Both beats in flight; hold the output so the first is not taken, then flush.
      out_ready = 1'b0; flush = 1'b1; in_a = 32'd7; in_b = 32'd7;
      #1;
      vectors++;
      if ({out_valid, in_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL flush_pre: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_kill: out_valid=%b want 0", out_valid);
      end
      in_valid = 1'b1; in_a = 32'h100; in_b = 32'h23;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ghost: out_valid=%b want 0", out_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, out_result} !== {1'b1, 32'h123}) begin
         miscompares++;
         $display("FAIL flush_after: valid=%b res=%h want 1 00000123", out_valid, out_result);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_after_drain: out_valid=%b want 0", out_valid);
      end
      // Flush on an empty pipe with in_valid & in_ready: the beat must be dropped.
      flush = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_ready: in_ready=%b want 1", in_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_block%0d: out_valid=%b want 0", i, out_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset_random();
      logic [65:0] q[$];
      logic [65:0] e;
      logic [63:0] bx, r;
      logic [64:0] s;
      int          issued = 0;
      int          done   = 0;
      out_ready_w = 1'b1; in_valid_w = 1'b1; in_sub_w = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_a_w = {$urandom, $urandom}; in_b_w = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      vectors++;
      if (out_valid_w !== 1'b1) begin
         miscompares++;
         $display("FAIL arst_pre: out_valid=%b want 1", out_valid_w);
      end
      #2;
      rst_w = 1'b1;
      #1;
      vectors++;
      if ({out_valid_w, out_result_w, out_carry_w, out_overflow_w, out_zero_w, in_ready_w} !==
          {1'b0, 64'h0, 3'b000, 1'b1}) begin
         miscompares++;
         $display("FAIL arst_now: valid=%b res=%h c=%b o=%b z=%b ready=%b want 0 0 0 0 0 1",
                  out_valid_w, out_result_w, out_carry_w, out_overflow_w, out_zero_w, in_ready_w);
      end
      in_valid_w = 1'b0;
      @(posedge clk); #1;
      rst_w = 1'b0;
      for (int cyc = 0; cyc < 20000 && done < 1000; cyc++) begin
         in_valid_w  = (issued < 1000) && ($urandom_range(3) != 0);
         out_ready_w = ($urandom_range(3) != 0);
         in_sub_w    = 1'($urandom_range(1));
         in_a_w      = {$urandom, $urandom};
         in_b_w      = ($urandom_range(15) == 0) ? in_a_w : {$urandom, $urandom};
         #1;
         if (out_valid_w && out_ready_w) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rand_extra: unexpected result %h", out_result_w);
            end else begin
               e = q.pop_front();
               if ({out_result_w, out_carry_w, out_overflow_w, out_zero_w} !==
                   {e, (e[65:2] == 64'h0)}) begin
                  miscompares++;
                  $display("FAIL rand%0d: got r=%h c=%b o=%b z=%b want r=%h c=%b o=%b",
                           done, out_result_w, out_carry_w, out_overflow_w, out_zero_w,
                           e[65:2], e[1], e[0]);
               end
            end
            done++;
         end
         if (in_valid_w && in_ready_w) begin
            bx = in_sub_w ? ~in_b_w : in_b_w;
            s  = {1'b0, in_a_w} + {1'b0, bx} + {64'h0, in_sub_w};
            r  = s[63:0];
            q.push_back({r, s[64], (in_a_w[63] == bx[63]) && (r[63] != in_a_w[63])});
            issued++;
         end
         @(posedge clk); #1;
      end
      in_valid_w = 1'b0;
      vectors++;
      if (done != 1000 || q.size() != 0) begin
         miscompares++;
         $display("FAIL rand_count: done=%0d pending=%0d want 1000 0", done, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_flush();
      test_async_reset_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
